adder_pipe: RTL
===============

# adder_pipe

Parametrised, pipelined N-bit adder/subtractor with valid/ready handshakes on input and output. It splits the operands into S equal chunks and resolves one chunk per pipeline stage, so a wide add closes timing at high clock rates. It sustains one operation per cycle. It sits between operand-producing datapath logic and any consumer that may apply backpressure, and it replaces the purely combinational fixed-width adder in wide or high-frequency paths.

## Interface
- N, default 16: operand/result width; must be a multiple of S.
- S, default 4: pipeline stages; chunk width W = N/S; S >= 1.

- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operand set this cycle.
- A  input  N  operand A, two's complement or unsigned.
- B  input  N  operand B.
- cIn  input  1  carry-in (add) / borrow-in (subtract).
- sub  input  1  0: add, 1: subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result this cycle.
- Sum  output  N  result.
- cOut  output  1  carry-out (add) / not-borrow (subtract).
- overflow  output  1  signed overflow flag.

## Operation
- Accept occurs when in_valid && in_ready at a rising edge; A, B, cIn, and sub are captured together.
- Effective operands:
  - sub=0: A + B + cIn.
  - sub=1: A + ~B + ~cIn, which equals A - B - cIn mod 2^N.
- cOut is bit N of the effective sum. In subtract mode, cOut=1 means no borrow.
- Stage k (0..S-1) adds chunk k of the effective operands plus the registered carry from stage k-1. Stage 0 uses the effective carry-in.
- Higher chunks ride skew registers until their stage. Lower result chunks ride deskew registers to the output.
- Each stage has a valid bit. Bubbles propagate and are not collapsed.
- Advance rule: advance = !out_valid || out_ready.
  - When advance=1, all stages shift by one.
  - When advance=0, the whole pipeline holds.
- in_ready = advance. It is combinational from out_valid and out_ready only, with no dependence on in_valid.
- Results leave in acceptance order. None are dropped or duplicated.
- Sum, cOut, and overflow hold stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1; out_valid=0; Sum=0; cOut=0; overflow=0. All stage valid bits are cleared.
- Reset mid-operation discards all in-flight operations. No result appears for them.
- Latency: a result accepted at edge t is presented (out_valid=1) after edge t+S-1, i.e. it is visible in the cycle after S edges counting the accept edge.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous accept and output consume in the same cycle is legal, and the pipeline stays full.
- S=1 degenerates to a single registered adder with latency 1.
- Carry wrap: a carry is propagated across all S chunk boundaries within the latency. For example, 0xFFFF + 1 yields Sum=0 and cOut=1.
- Width rule: the internal chunk sum is W+1 bits. The MSB is the registered carry into the next stage.

## Configuration
- ADDER_PIPE_OVF_EN defined:
  - overflow = (sign of effective A == sign of effective B) && (sign of Sum != sign of effective A).
  - It is computed in the last stage and delivered aligned with Sum.
- ADDER_PIPE_OVF_EN undefined:
  - overflow is tied to 0.
  - No sign-tracking registers are instantiated.
  - Sum, cOut, latency, and handshake behaviour are unchanged.

## Test plan
All scenarios use N=16 and S=4.
- Add 0x00FF + 0x0001, cIn=0, out_ready=1 -> Sum=0x0100, cOut=0 exactly 4 cycles after accept.
- Add 0xFFFF + 0x0000, cIn=1 -> Sum=0x0000, cOut=1 (full chunk-carry ripple).
- Subtract 0x0005 - 0x0007, cIn=0 -> Sum=0xFFFE, cOut=0, overflow=0. Subtract 0x8000 - 0x0001 -> Sum=0x7FFF, cOut=1, overflow=1 (macro on) / 0 (macro off).
- Add 0x7FFF + 0x0001 -> Sum=0x8000, overflow=1 (macro on) / 0 (macro off).
- Stream 8 back-to-back operations; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold, outputs stable, all 8 results in order with none lost or duplicated.
- Accept 3 operations, assert rst for 1 cycle -> next cycle out_valid=0, Sum=0, and none of the 3 results ever appears.

Source files
------------

// File: rtl/adder_pipe.sv
// Pipelined N-bit add/subtract, one W=N/S chunk resolved per stage; latency S cycles, one op per cycle.
// Backpressure stalls the whole pipeline: in_ready = !out_valid || out_ready (forced low during rst).
// Define ADDER_PIPE_OVF_EN to build the signed-overflow flag; otherwise overflow is tied low.
module adder_pipe #(
    parameter int N = 16,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cIn,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         cOut,
    output logic         overflow
);
    localparam int W = N / S;

    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    genvar k;
    for (k = 0; k < S; k++) begin : g_stg
        // Operand bits still waiting for their stage: chunk k sits in the low W bits.
        localparam int AW = N - k * W;

        logic [AW-1:0]        a_in;
        logic [AW-1:0]        b_in;
        logic                 c_in;
        logic                 v_in;
        logic [W:0]           csum;
        logic                 vld_q;
        logic                 c_q;
        logic [(k+1)*W-1:0]   r_q;

        if (k == 0) begin : g_src
            assign a_in = A;
            assign b_in = sub ? ~B : B;
            assign c_in = sub ? ~cIn : cIn;
            assign v_in = in_valid;
        end else begin : g_src
            assign a_in = g_stg[k-1].g_skew.a_q;
            assign b_in = g_stg[k-1].g_skew.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign v_in = g_stg[k-1].vld_q;
        end

        assign csum = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
            end else if (advance) begin
                vld_q <= v_in;
                c_q   <= csum[W];
            end
        end

        // Finished low chunks are carried along beside the new chunk.
        if (k == 0) begin : g_res
            always_ff @(posedge clk) begin
                if (rst)
                    r_q <= '0;
                else if (advance)
                    r_q <= csum[W-1:0];
            end
        end else begin : g_res
            always_ff @(posedge clk) begin
                if (rst)
                    r_q <= '0;
                else if (advance)
                    r_q <= {csum[W-1:0], g_stg[k-1].r_q};
            end
        end

        if (k < S - 1) begin : g_skew
            logic [AW-W-1:0] a_q;
            logic [AW-W-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[AW-1:W];
                    b_q <= b_in[AW-1:W];
                end
            end
        end
    end

    assign out_valid = g_stg[S-1].vld_q;
    assign Sum       = g_stg[S-1].r_q;
    assign cOut      = g_stg[S-1].c_q;

`ifdef ADDER_PIPE_OVF_EN
    // Last stage sees the sign bits of both effective operands and of the result chunk.
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (advance)
            ovf_q <= (g_stg[S-1].a_in[W-1] == g_stg[S-1].b_in[W-1]) &&
                     (g_stg[S-1].csum[W-1] != g_stg[S-1].a_in[W-1]);
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
